// File: rtl/inverter_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the inverter arbiter.
package inverter_arbiter_pkg;

    localparam int INV_WIDTH = 32;
    localparam int STAT_W    = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/inverter_arbiter_inv.sv
// Combinational bitwise inverter datapath shared by all arbiter requesters.
module inverter_arbiter_inv #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = ~a;

endmodule

// File: rtl/inverter_arbiter.sv
// Round-robin arbiter sharing one inverter datapath among NUM_REQ requesters.
// Optional macro INVERTER_ARBITER_STATS_EN adds per-requester grant and stall counters.
//
//  state | meaning
//  IDLE  | no result held, out_valid=0
//  FULL  | result held on out_data/out_id, out_valid=1
module inverter_arbiter
    import inverter_arbiter_pkg::*;
#(
    parameter int  WIDTH   = INV_WIDTH,
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]          out_id,
    input  logic                     out_ready
`ifdef INVERTER_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] stat_grants,
    output logic [STAT_W-1:0]         stat_stall
`endif
);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_id;
    logic              found, can_accept, grant;
    logic [WIDTH-1:0]  operand, inv_result;

    // Returns {hit, index} of the first valid requester at or after ptr, wrapping explicitly.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
        logic            hit;
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx;
        int              pos;
        hit  = 1'b0;
        pick = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            idx = ID_W'(pos);
            if (!hit && valid[idx]) begin
                hit  = 1'b1;
                pick = idx;
            end
        end
        return {hit, pick};
    endfunction

    always_comb begin
        {found, grant_id} = rr_pick(req_valid, rr_ptr_q);
        can_accept = (state_q == IDLE) || ((state_q == FULL) && out_ready);
        grant      = found && can_accept && !rst;
        req_ready  = '0;
        if (grant) req_ready[grant_id] = 1'b1;
        operand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) operand = req_data[i*WIDTH +: WIDTH];
        end
    end

    inverter_arbiter_inv #(
        .WIDTH (WIDTH)
    ) u_inv (
        .a (operand),
        .y (inv_result)
    );

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (grant) begin
            state_d    = FULL;
            out_data_d = inv_result;
            out_id_d   = grant_id;
            rr_ptr_d   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end else if ((state_q == FULL) && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            out_data_q <= '0;
            out_id_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

`ifdef INVERTER_ARBITER_STATS_EN
    logic [STAT_W-1:0] grant_cnt_q [NUM_REQ];
    logic [STAT_W-1:0] grant_cnt_d [NUM_REQ];
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == FULL) && !out_ready && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            if (req_ready[i] && (grant_cnt_q[i] != '1))
                grant_cnt_d[i] = grant_cnt_q[i] + STAT_W'(1);
            stat_grants[i*STAT_W +: STAT_W] = grant_cnt_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
        end
    end

    assign stat_stall = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inverter_arbiter.sv
// Scoreboard bench for inverter_arbiter: expected results queued at grant, compared when the result appears.
// Stats ports are exercised when INVERTER_ARBITER_STATS_EN is defined.
module tb_inverter_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_id;
    logic           out_ready = 1'b0;
`ifdef INVERTER_ARBITER_STATS_EN
    logic [N*16-1:0] stat_grants;
    logic [15:0]     stat_stall;
`endif

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    inverter_arbiter #(
        .WIDTH   (W),
        .NUM_REQ (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
`ifdef INVERTER_ARBITER_STATS_EN
        ,
        .stat_grants (stat_grants),
        .stat_stall  (stat_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [31:0] d);
        req_data[i*W +: W] = d;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [31:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sb_q.push_back(e);
    endtask

    function automatic exp_t pop_exp();
        exp_t e;
        if (sb_q.size() == 0) e = 'x;
        else e = sb_q.pop_front();
        return e;
    endfunction

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
        tick(); tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_id !== 2'd0 || req_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL por_state: got v=%b data=%h id=%0d rdy=%b, want v=0 data=0 id=0 rdy=0", out_valid, out_data, out_id, req_ready);
        end
        rst = 1'b0; req_valid = 4'b0010; set_data(1, 32'h1234_5678);
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL first_grant_rdy: got %b, want 0010", req_ready);
        end
        push_exp(2'd1, 32'hEDCB_A987);
        tick();
        req_valid = '0;
        e = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== e.id || out_data !== e.data) begin
            n_fail++;
            $display("FAIL first_grant_out: got v=%b id=%0d data=%h, want v=1 id=%0d data=%h", out_valid, out_id, out_data, e.id, e.data);
        end
        tick();
        rst = 1'b1; req_valid = 4'b1111;
        #1;
        n_checks++;
        if (req_ready !== 4'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_in_reset: got rdy=%b v=%b, want rdy=0000 v=1", req_ready, out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_id !== 2'd0 || req_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got v=%b data=%h id=%0d rdy=%b, want v=0 data=0 id=0 rdy=0", out_valid, out_data, out_id, req_ready);
        end
        rst = 1'b0; out_ready = 1'b1; set_data(0, 32'h0F0F_0000);
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL post_reset_grant0: got %b, want 0001", req_ready);
        end
        push_exp(2'd0, 32'hF0F0_FFFF);
        tick();
        req_valid = '0;
        e = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== e.id || out_data !== e.data) begin
            n_fail++;
            $display("FAIL post_reset_out: got v=%b id=%0d data=%h, want v=1 id=%0d data=%h", out_valid, out_id, out_data, e.id, e.data);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_idle: got v=%b, want 0", out_valid);
        end
    endtask

    task automatic test_single();
        exp_t e;
        req_valid = 4'b0100; set_data(2, 32'h0000_0001); out_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_rdy: got %b, want 0100", req_ready);
        end
        push_exp(2'd2, 32'hFFFF_FFFE);
        tick();
        req_valid = '0;
        e = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== e.id || out_data !== e.data) begin
            n_fail++;
            $display("FAIL single_out: got v=%b id=%0d data=%h, want v=1 id=%0d data=%h", out_valid, out_id, out_data, e.id, e.data);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || req_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL no_req_idle: got v=%b rdy=%b, want v=0 rdy=0000", out_valid, req_ready);
        end
    endtask

    task automatic test_all_valid();
        exp_t        e;
        logic [31:0] dv [N];
        logic [3:0]  exp_rdy;
        rst = 1'b1; req_valid = '0;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            dv[i] = 32'h1111_1111 * (i + 1);
            set_data(i, dv[i]);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            n_checks++;
            if (req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rr_rdy[%0d]: got %b, want %b", k, req_ready, exp_rdy);
            end
            push_exp(2'(k % 4), ~dv[k % 4]);
            tick();
            e = pop_exp();
            n_checks++;
            if (out_valid !== 1'b1 || out_id !== e.id || out_data !== e.data) begin
                n_fail++;
                $display("FAIL rr_out[%0d]: got v=%b id=%0d data=%h, want v=1 id=%0d data=%h", k, out_valid, out_id, out_data, e.id, e.data);
            end
        end
        req_valid = '0;
`ifdef INVERTER_ARBITER_STATS_EN
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (stat_grants[i*16 +: 16] !== 16'd2) begin
                n_fail++;
                $display("FAIL stat_grants[%0d]: got %0d, want 2", i, stat_grants[i*16 +: 16]);
            end
        end
        n_checks++;
        if (stat_stall !== 16'd0) begin
            n_fail++;
            $display("FAIL stat_stall_rr: got %0d, want 0", stat_stall);
        end
`endif
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_drain: got v=%b, want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        req_valid = 4'b0011; set_data(0, 32'hCAFE_0000); set_data(1, 32'h0000_BEEF); out_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_first_rdy: got %b, want 0001", req_ready);
        end
        push_exp(2'd0, 32'h3501_FFFF);
        tick();
        out_ready = 1'b0; req_valid = 4'b0010;
        e = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== e.id || out_data !== e.data) begin
            n_fail++;
            $display("FAIL bp_first_out: got v=%b id=%0d data=%h, want v=1 id=%0d data=%h", out_valid, out_id, out_data, e.id, e.data);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0 || out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 32'h3501_FFFF) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b id=%0d data=%h, want rdy=0000 v=1 id=0 data=3501ffff", k, req_ready, out_valid, out_id, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_release_rdy: got %b, want 0010", req_ready);
        end
        push_exp(2'd1, 32'hFFFF_4110);
        tick();
        req_valid = '0;
        e = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== e.id || out_data !== e.data) begin
            n_fail++;
            $display("FAIL bp_release_out: got v=%b id=%0d data=%h, want v=1 id=%0d data=%h", out_valid, out_id, out_data, e.id, e.data);
        end
`ifdef INVERTER_ARBITER_STATS_EN
        n_checks++;
        if (stat_stall !== 16'd5) begin
            n_fail++;
            $display("FAIL stat_stall_bp: got %0d, want 5", stat_stall);
        end
`endif
        tick();
    endtask

    task automatic test_extremes();
        exp_t e;
        req_valid = 4'b0100; set_data(2, 32'h0000_0000); out_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL ext_zero_rdy: got %b, want 0100", req_ready);
        end
        push_exp(2'd2, 32'hFFFF_FFFF);
        tick();
        e = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== e.id || out_data !== e.data) begin
            n_fail++;
            $display("FAIL ext_zero_out: got v=%b id=%0d data=%h, want v=1 id=%0d data=%h", out_valid, out_id, out_data, e.id, e.data);
        end
        req_valid = 4'b0001; set_data(0, 32'hFFFF_FFFF);
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL ext_ones_rdy: got %b, want 0001", req_ready);
        end
        push_exp(2'd0, 32'h0000_0000);
        tick();
        req_valid = '0;
        e = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== e.id || out_data !== e.data) begin
            n_fail++;
            $display("FAIL ext_ones_out: got v=%b id=%0d data=%h, want v=1 id=%0d data=%h", out_valid, out_id, out_data, e.id, e.data);
        end
        tick();
    endtask

    task automatic test_wrap();
        exp_t e;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid = 4'b1000; set_data(3, 32'h5A5A_0000 + k);
            #1;
            n_checks++;
            if (req_ready !== 4'b1000) begin
                n_fail++;
                $display("FAIL wrap_rdy[%0d]: got %b, want 1000", k, req_ready);
            end
            push_exp(2'd3, ~(32'h5A5A_0000 + k));
            tick();
            e = pop_exp();
            n_checks++;
            if (out_valid !== 1'b1 || out_id !== e.id || out_data !== e.data) begin
                n_fail++;
                $display("FAIL wrap_out[%0d]: got v=%b id=%0d data=%h, want v=1 id=%0d data=%h", k, out_valid, out_id, out_data, e.id, e.data);
            end
        end
        req_valid = 4'b1111; set_data(0, 32'h0000_00FF);
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_ptr0: got %b, want 0001", req_ready);
        end
        push_exp(2'd0, 32'hFFFF_FF00);
        tick();
        req_valid = '0;
        e = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== e.id || out_data !== e.data) begin
            n_fail++;
            $display("FAIL wrap_ptr0_out: got v=%b id=%0d data=%h, want v=1 id=%0d data=%h", out_valid, out_id, out_data, e.id, e.data);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_drain: got v=%b pending=%0d, want v=0 pending=0", out_valid, sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_valid();
        test_backpressure();
        test_extremes();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t reached, required completion before 200000", $time);
        $fatal(1);
    end

endmodule
